// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: ready/valid transfer request and receive bus between the CPU side and the SPI master
// master modport: CPU side (drives tx_valid/tx_data/tx_ss_sel, sees tx_ready/rx_valid/rx_data)
// slave modport:  SPI controller (accepts requests, returns received words)
interface spi_master_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4
);
    logic                      tx_valid;
    logic                      tx_ready;
    logic [DATA_W-1:0]         tx_data;
    logic [$clog2(NUM_SS)-1:0] tx_ss_sel;
    logic                      rx_valid;
    logic [DATA_W-1:0]         rx_data;
    modport master (output tx_valid, tx_data, tx_ss_sel, input tx_ready, rx_valid, rx_data);
    modport slave (input tx_valid, tx_data, tx_ss_sel, output tx_ready, rx_valid, rx_data);
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: full-duplex SPI master, all CPOL/CPHA modes, programmable divider and length
// clk, rst        : system clock, async active-high reset
// cfg_cpol/cpha   : SPI mode, latched on accept
// cfg_div         : SCK half-period = cfg_div+1 clk cycles, latched on accept
// cfg_len         : bits per transfer minus 1, latched on accept
// bus (slave)     : tx ready/valid request with data and slave select, rx_valid pulse with rx_data
// busy            : controller not in IDLE
// sck, ss_n, mosi : SPI outputs; miso: SPI input (already synchronised by the caller)
module spi_master_ctrl #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_cpol,
    input  logic                      cfg_cpha,
    input  logic [DIV_W-1:0]          cfg_div,
    input  logic [$clog2(DATA_W)-1:0] cfg_len,
    spi_master_ctrl_if.slave          bus,
    output logic                      busy,
    output logic                      sck,
    output logic [NUM_SS-1:0]         ss_n,
    output logic                      mosi,
    input  logic                      miso
);
    localparam int LW = $clog2(DATA_W);
    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;
    state_t            state;
    logic              cpha_l;
    logic              lead;
    logic [DIV_W-1:0]  div_l;
    logic [DIV_W-1:0]  cnt;
    logic [LW:0]       bit_cnt;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] aligned;
    logic              accept;
    logic              hp_end;
    assign accept = bus.tx_valid & bus.tx_ready;
    assign hp_end = cnt == '0;
    // bit cfg_len of the word moved to the MSB so shifting out is always from the top
    assign aligned = bus.tx_data << (LW'(DATA_W - 1) - cfg_len);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sck          <= 1'b0;
            ss_n         <= '1;
            mosi         <= 1'b0;
            busy         <= 1'b0;
            bus.tx_ready <= 1'b0;
            bus.rx_valid <= 1'b0;
            bus.rx_data  <= '0;
            cpha_l       <= 1'b0;
            lead         <= 1'b0;
            div_l        <= '0;
            cnt          <= '0;
            bit_cnt      <= '0;
            sh           <= '0;
            rx_sh        <= '0;
        end else begin
            bus.rx_valid <= 1'b0;
            cnt <= hp_end ? div_l : cnt - 1'b1;
            case (state)
                IDLE: begin
                    sck <= cfg_cpol;
                    bus.tx_ready <= !accept;
                    if (accept) begin
                        state   <= LEAD;
                        busy    <= 1'b1;
                        cpha_l  <= cfg_cpha;
                        div_l   <= cfg_div;
                        cnt     <= cfg_div;
                        bit_cnt <= {1'b0, cfg_len};
                        ss_n    <= ~(NUM_SS'(1) << bus.tx_ss_sel);
                        rx_sh   <= '0;
                        // CPHA=0 needs the first bit on mosi before the first edge
                        mosi    <= cfg_cpha ? 1'b0 : aligned[DATA_W-1];
                        sh      <= cfg_cpha ? aligned : aligned << 1;
                    end
                end
                LEAD: if (hp_end) begin
                    state <= SHIFT;
                    lead  <= 1'b1;
                end
                SHIFT: if (hp_end) begin
                    sck  <= ~sck;
                    lead <= ~lead;
                    // shift-out edge: trailing for CPHA=0, leading for CPHA=1; the other edge samples
                    if (lead == cpha_l) begin
                        mosi <= sh[DATA_W-1];
                        sh   <= sh << 1;
                    end else begin
                        rx_sh <= {rx_sh[DATA_W-2:0], miso};
                    end
                    if (!lead) begin
                        if (bit_cnt == '0) state <= TRAIL;
                        else bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                TRAIL: if (hp_end) begin
                    state        <= GAP;
                    ss_n         <= '1;
                    mosi         <= 1'b0;
                    bus.rx_valid <= 1'b1;
                    bus.rx_data  <= rx_sh;
                end
                GAP: if (hp_end) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_cpol = 1'b0;
    logic       cfg_cpha = 1'b0;
    logic [7:0] cfg_div = 8'd0;
    logic [2:0] cfg_len = 3'd7;
    logic       busy, sck, mosi, miso;
    logic [3:0] ss_n;
    spi_master_ctrl_if #(.DATA_W(8), .NUM_SS(4)) bus ();
    spi_master_ctrl #(.DATA_W(8), .NUM_SS(4), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_div(cfg_div),
        .cfg_len(cfg_len), .bus(bus), .busy(busy), .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso)
    );
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    logic       slave_en = 1'b0;
    logic       slave_bit = 1'b0;
    logic [7:0] slave_word = 8'h00;
    int         slave_idx = 0;
    int   ss_low, sck_rise, sck_tog, lvl_min, lvl_max, run, rxv_n, hi_run, gap_min, mosi_n;
    logic sck_p, have_tog, seen_low, other_low;
    logic [7:0] mosi_bits;
    assign miso = slave_en ? slave_bit : mosi;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    // slave model for CPHA=1: drives the next bit on every leading (falling in mode 3) edge
    always @(negedge sck) begin
        if (slave_en && ss_n != 4'hF && slave_idx >= 0) begin
            slave_bit = slave_word[slave_idx];
            slave_idx--;
        end
    end
    always @(negedge clk) begin
        if (!rst) begin
            if (ss_n == 4'hF) have_tog = 1'b0;
            if (ss_n != 4'hF) ss_low++;
            if (ss_n[2:0] != 3'b111) other_low = 1'b1;
            if (bus.rx_valid) rxv_n++;
            if (ss_n == 4'hF) hi_run++;
            else begin
                if (seen_low && hi_run > 0 && hi_run < gap_min) gap_min = hi_run;
                hi_run = 0;
                seen_low = 1'b1;
            end
            if (sck !== sck_p) begin
                if (ss_n != 4'hF) begin
                    sck_tog++;
                    if (sck) sck_rise++;
                    if (have_tog) begin
                        if (run < lvl_min) lvl_min = run;
                        if (run > lvl_max) lvl_max = run;
                    end
                    if ((sck == cfg_cpol) == cfg_cpha) begin
                        mosi_bits = {mosi_bits[6:0], mosi};
                        mosi_n++;
                    end
                    have_tog = 1'b1;
                end
                run = 1;
            end else begin
                run++;
            end
            sck_p = sck;
        end
    end
    task automatic clr_mon;
        ss_low = 0; sck_rise = 0; sck_tog = 0; lvl_min = 1000; lvl_max = 0; run = 0; rxv_n = 0;
        hi_run = 0; gap_min = 1000; mosi_n = 0; sck_p = sck; have_tog = 1'b0; seen_low = 1'b0;
        other_low = 1'b0; mosi_bits = 8'h00;
    endtask
    task automatic xfer(input logic [7:0] d, input logic [1:0] sel, input int chg_at,
                        output logic [7:0] got, output int lat, output logic sck_rx, output bit to);
        int n;
        int a;
        got = 8'h00; lat = 0; sck_rx = 1'b0; to = 1'b0;
        @(negedge clk);
        bus.tx_data = d; bus.tx_ss_sel = sel; bus.tx_valid = 1'b1;
        n = 0;
        while (!bus.tx_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus.tx_ready) begin to = 1'b1; bus.tx_valid = 1'b0; return; end
        a = cyc + 1;
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        if (chg_at > 0) begin
            repeat (chg_at) @(negedge clk);
            cfg_div = 8'd3; cfg_cpol = 1'b1;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rx_valid && n < 2000);
        if (!bus.rx_valid) begin to = 1'b1; return; end
        got = bus.rx_data; sck_rx = sck;
        n = 0;
        while (!bus.tx_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus.tx_ready) to = 1'b1;
        lat = cyc - a;
    endtask
    task automatic test_reset;
        bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.tx_ss_sel = 2'd0;
        #3 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (sck !== 1'b0) begin fails++; $display("FAIL reset_sck: got %b want 0", sck); end
        checks++; if (ss_n !== 4'hF) begin fails++; $display("FAIL reset_ss_n: got %h want f", ss_n); end
        checks++; if (mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        checks++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL reset_tx_ready: got %b want 0", bus.tx_ready); end
        rst = 1'b0;
        clr_mon;
        @(posedge clk);
        #1;
        checks++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after: got %b want 1", bus.tx_ready); end
    endtask
    task automatic test_mode0_loop;
        logic [7:0] got; int lat; logic sr; bit to;
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_div = 8'd0; cfg_len = 3'd7; slave_en = 1'b0;
        repeat (2) @(negedge clk);
        clr_mon;
        xfer(8'hA5, 2'd0, 0, got, lat, sr, to);
        checks++; if (to !== 1'b0) begin fails++; $display("FAIL m0_timeout: got %b want 0", to); end
        checks++; if (got !== 8'hA5) begin fails++; $display("FAIL m0_rx_data: got %h want a5", got); end
        checks++; if (sck_rise !== 8) begin fails++; $display("FAIL m0_sck_rises: got %0d want 8", sck_rise); end
        checks++; if (ss_low !== 18) begin fails++; $display("FAIL m0_ss_low: got %0d want 18", ss_low); end
        checks++; if (lat !== 20) begin fails++; $display("FAIL m0_ready_latency: got %0d want 20", lat); end
        checks++; if (sr !== 1'b0) begin fails++; $display("FAIL m0_sck_idle: got %b want 0", sr); end
        checks++; if (rxv_n !== 1) begin fails++; $display("FAIL m0_rx_pulses: got %0d want 1", rxv_n); end
    endtask
    task automatic test_mode3_slave;
        logic [7:0] got; int lat; logic sr; bit to;
        cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_div = 8'd2; cfg_len = 3'd7;
        slave_word = 8'h3C; slave_idx = 7; slave_bit = 1'b0; slave_en = 1'b1;
        repeat (2) @(negedge clk);
        clr_mon;
        xfer(8'h81, 2'd1, 0, got, lat, sr, to);
        slave_en = 1'b0;
        checks++; if (to !== 1'b0) begin fails++; $display("FAIL m3_timeout: got %b want 0", to); end
        checks++; if (got !== 8'h3C) begin fails++; $display("FAIL m3_rx_data: got %h want 3c", got); end
        checks++; if (lvl_min !== 3 || lvl_max !== 3) begin fails++; $display("FAIL m3_sck_level: got %0d..%0d want 3..3", lvl_min, lvl_max); end
        checks++; if (sr !== 1'b1) begin fails++; $display("FAIL m3_sck_idle: got %b want 1", sr); end
        checks++; if (ss_low !== 54) begin fails++; $display("FAIL m3_ss_low: got %0d want 54", ss_low); end
        checks++; if (lat !== 58) begin fails++; $display("FAIL m3_ready_latency: got %0d want 58", lat); end
    endtask
    task automatic test_short_len;
        logic [7:0] got; int lat; logic sr; bit to;
        for (int m = 1; m <= 2; m++) begin
            cfg_cpol = (m == 2); cfg_cpha = 1'b1; cfg_div = 8'd1; cfg_len = 3'd3; slave_en = 1'b0;
            repeat (2) @(negedge clk);
            clr_mon;
            xfer(8'h0D, 2'd2, 0, got, lat, sr, to);
            checks++; if (got !== 8'h0D || to) begin fails++; $display("FAIL len4_mode%0d_rx: got %h want 0d", m, got); end
            checks++; if (sck_tog !== 8) begin fails++; $display("FAIL len4_mode%0d_sck_edges: got %0d want 8", m, sck_tog); end
            checks++; if (mosi_n !== 4 || mosi_bits[3:0] !== 4'b1101) begin fails++; $display("FAIL len4_mode%0d_mosi: got %0d bits %b want 4 bits 1101", m, mosi_n, mosi_bits[3:0]); end
            checks++; if (ss_low !== 20) begin fails++; $display("FAIL len4_mode%0d_ss_low: got %0d want 20", m, ss_low); end
        end
    endtask
    task automatic test_back_to_back;
        int n; logic [7:0] r1, r2; bit to;
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_div = 8'd1; cfg_len = 3'd7; slave_en = 1'b0;
        r1 = 8'h00; r2 = 8'h00; to = 1'b0;
        repeat (2) @(negedge clk);
        clr_mon;
        bus.tx_data = 8'h12; bus.tx_ss_sel = 2'd3; bus.tx_valid = 1'b1;
        n = 0;
        while (!bus.tx_ready && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 bus.tx_data = 8'h34;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rx_valid && n < 2000);
        if (bus.rx_valid) r1 = bus.rx_data; else to = 1'b1;
        n = 0;
        while (!bus.tx_ready && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rx_valid && n < 2000);
        if (bus.rx_valid) r2 = bus.rx_data; else to = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (to !== 1'b0) begin fails++; $display("FAIL b2b_timeout: got %b want 0", to); end
        checks++; if (r1 !== 8'h12) begin fails++; $display("FAIL b2b_first: got %h want 12", r1); end
        checks++; if (r2 !== 8'h34) begin fails++; $display("FAIL b2b_second: got %h want 34", r2); end
        checks++; if (rxv_n !== 2) begin fails++; $display("FAIL b2b_rx_pulses: got %0d want 2", rxv_n); end
        checks++; if (other_low !== 1'b0) begin fails++; $display("FAIL b2b_other_ss: got %b want 0", other_low); end
        checks++; if (gap_min !== 4) begin fails++; $display("FAIL b2b_ss_gap: got %0d want 4", gap_min); end
        checks++; if (ss_low !== 72) begin fails++; $display("FAIL b2b_ss_low: got %0d want 72", ss_low); end
    endtask
    task automatic test_cfg_change;
        logic [7:0] got; int lat; logic sr; bit to;
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_div = 8'd1; cfg_len = 3'd7; slave_en = 1'b0;
        repeat (2) @(negedge clk);
        clr_mon;
        xfer(8'h5A, 2'd0, 6, got, lat, sr, to);
        checks++; if (got !== 8'h5A || to) begin fails++; $display("FAIL cfg_old_rx: got %h want 5a", got); end
        checks++; if (ss_low !== 36) begin fails++; $display("FAIL cfg_old_ss_low: got %0d want 36", ss_low); end
        checks++; if (lvl_min !== 2 || lvl_max !== 2) begin fails++; $display("FAIL cfg_old_level: got %0d..%0d want 2..2", lvl_min, lvl_max); end
        checks++; if (lat !== 39) begin fails++; $display("FAIL cfg_old_latency: got %0d want 39", lat); end
        checks++; if (sr !== 1'b0) begin fails++; $display("FAIL cfg_old_sck_idle: got %b want 0", sr); end
        repeat (2) @(negedge clk);
        clr_mon;
        xfer(8'hC3, 2'd0, 0, got, lat, sr, to);
        checks++; if (got !== 8'hC3 || to) begin fails++; $display("FAIL cfg_new_rx: got %h want c3", got); end
        checks++; if (ss_low !== 72) begin fails++; $display("FAIL cfg_new_ss_low: got %0d want 72", ss_low); end
        checks++; if (lvl_min !== 4 || lvl_max !== 4) begin fails++; $display("FAIL cfg_new_level: got %0d..%0d want 4..4", lvl_min, lvl_max); end
        checks++; if (lat !== 77) begin fails++; $display("FAIL cfg_new_latency: got %0d want 77", lat); end
        checks++; if (sr !== 1'b1) begin fails++; $display("FAIL cfg_new_sck_idle: got %b want 1", sr); end
    endtask
    task automatic test_reset_abort;
        int n; logic pre;
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_div = 8'd1; cfg_len = 3'd7; slave_en = 1'b0;
        repeat (2) @(negedge clk);
        clr_mon;
        bus.tx_data = 8'hF0; bus.tx_ss_sel = 2'd2; bus.tx_valid = 1'b1;
        n = 0;
        while (!bus.tx_ready && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        repeat (8) @(negedge clk);
        n = 0;
        while (!sck && n < 20) begin @(negedge clk); n++; end
        pre = sck;
        #2 rst = 1'b1;
        #1;
        checks++; if (pre !== 1'b1) begin fails++; $display("FAIL abort_sck_before: got %b want 1", pre); end
        checks++; if (ss_n !== 4'hF) begin fails++; $display("FAIL abort_ss_n: got %h want f", ss_n); end
        checks++; if (sck !== 1'b0) begin fails++; $display("FAIL abort_sck: got %b want 0", sck); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL abort_tx_ready: got %b want 0", bus.tx_ready); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL abort_ready_after: got %b want 1", bus.tx_ready); end
        repeat (40) @(negedge clk);
        checks++; if (rxv_n !== 0) begin fails++; $display("FAIL abort_rx_pulses: got %0d want 0", rxv_n); end
        checks++; if (ss_n !== 4'hF) begin fails++; $display("FAIL abort_ss_idle: got %h want f", ss_n); end
    endtask
    initial begin
        test_reset;
        test_mode0_loop;
        test_mode3_slave;
        test_short_len;
        test_back_to_back;
        test_cfg_change;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
